// File: rtl/op_codes_pkg.sv
// op_codes_pkg: operate-code field values, UART frame levels and transmitter states
package op_codes_pkg;
  localparam logic [1:0] CHAN_OPERATE = 2'b10;
  localparam logic [4:0] OP_NULL = 5'b00000;
  localparam logic [4:0] OP_GET = 5'b00001;
  localparam logic [4:0] OP_PUT = 5'b00010;
  localparam logic [4:0] OP_INTERACT = 5'b00100;
  localparam logic [4:0] OP_MOVE = 5'b01000;
  localparam logic [4:0] OP_THROW = 5'b10000;
  localparam logic [4:0] OP_ANY = OP_GET | OP_PUT | OP_INTERACT | OP_MOVE | OP_THROW;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  // multi-hot op fields are accepted; only a change of op field counts as a new code
  function automatic logic is_op_code(input logic [7:0] d, input logic [4:0] prev_op);
    return d[1:0] == CHAN_OPERATE && (d[6:2] & OP_ANY) != OP_NULL && d[6:2] != prev_op;
  endfunction
endpackage

// File: rtl/op_uart_sender_if.sv
// op_uart_sender_if: operate-code input, UART line and status flags
interface op_uart_sender_if;
  logic [7:0] data_in;
  logic clear_ovf;
  logic tx;
  logic busy;
  logic overflow;
  modport master(output data_in, clear_ovf, input tx, busy, overflow);
  modport slave(input data_in, clear_ovf, output tx, busy, overflow);
endinterface

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer, accepts a byte whenever idle
module uart_tx_byte
  import op_codes_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);
  localparam int CW = $clog2(DIV);
  tx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  logic tx_n, last;
  assign last = cnt == CW'(DIV - 1);
  assign ready = state == IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      tx <= STOP_BIT;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      tx <= tx_n;
    end
  // state only changes on a bit boundary (or out of IDLE), so the counter restarts on every entry
  always_comb begin
    state_n = state;
    cnt_n = (last || state == IDLE) ? '0 : cnt + 1'b1;
    idx_n = idx;
    sh_n = sh;
    tx_n = STOP_BIT;
    case (state)
      IDLE: if (valid) begin
        state_n = START;
        sh_n = data;
      end
      START: begin
        tx_n = START_BIT;
        if (last) begin
          state_n = DATA;
          idx_n = '0;
        end
      end
      DATA: begin
        tx_n = sh[0];
        if (last) begin
          sh_n = sh >> 1;
          idx_n = idx + 1'b1;
          state_n = idx == 3'd7 ? STOP : DATA;
        end
      end
      STOP: state_n = last ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: rtl/op_uart_sender.sv
// op_uart_sender: captures new operate codes into a FIFO and sends them over UART 8N1
module op_uart_sender
  import op_codes_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  op_uart_sender_if.slave bus
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic [4:0] prev_op;
  logic valid, full, empty, ready, pop, push;
  assign valid = is_op_code(bus.data_in, prev_op);
  assign empty = wp == rp;
  assign full = wp == {~rp[AW], rp[AW-1:0]};
  assign pop = ready & ~empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push = valid & (~full | pop);
  uart_tx_byte #(.DIV(DIV)) u_tx (
    .clk(clk),
    .rst_n(rst_n),
    .data(mem[rp[AW-1:0]]),
    .valid(~empty),
    .ready(ready),
    .tx(bus.tx)
  );
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= {1'b0, bus.data_in[6:0]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      prev_op <= OP_NULL;
      bus.overflow <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      prev_op <= bus.data_in[6:2];
      wp <= wp + (AW + 1)'(push);
      rp <= rp + (AW + 1)'(pop);
      bus.overflow <= (valid & full & ~pop) | (bus.overflow & ~bus.clear_ovf);
      bus.busy <= ~ready | ~empty;
    end
endmodule

// File: tb/tb_op_uart_sender.sv
// tb_op_uart_sender: randomized and directed checks using a UART frame decoder and expected-byte queue
module tb_op_uart_sender;
  localparam int DIV = 10;
  localparam int FRAME = 10 * DIV;
  typedef struct {logic [7:0] b; logic st; logic sp; int t0;} frame_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0, n_chk = 0, n_pass = 0, rel, tx_low = 0;
  bit rx_act = 1'b0;
  frame_t cur;
  frame_t rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_in = 8'h02;

  op_uart_sender_if bus();
  op_uart_sender #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // line decoder: samples each bit at its centre, relative to the observed start edge
  always @(negedge clk) begin
    if (!rst_n) rx_act = 1'b0;
    else begin
      if (bus.tx === 1'b0) tx_low++;
      if (!rx_act) begin
        if (bus.tx === 1'b0) begin
          rx_act = 1'b1;
          cur.t0 = cyc;
        end
      end else begin
        rel = cyc - cur.t0;
        if (rel == DIV / 2) cur.st = bus.tx;
        else if (rel % DIV == DIV / 2 && rel / DIV >= 1 && rel / DIV <= 8) cur.b[rel/DIV-1] = bus.tx;
        else if (rel == 9 * DIV + DIV / 2) begin
          cur.sp = bus.tx;
          rx_q.push_back(cur);
          rx_act = 1'b0;
        end
      end
    end
  end

  function automatic bit valid_code(input logic [7:0] d, input logic [7:0] p);
    return d[1:0] == 2'b10 && d[6:2] != 5'd0 && d[6:2] != p[6:2];
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d);
    tick();
    bus.data_in = d;
    if (valid_code(d, last_in)) exp_q.push_back({1'b0, d[6:0]});
    last_in = d;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 3000 && !ok; i++) begin
      tick();
      ok = !bus.busy && !rx_act;
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    int low0;
    bus.data_in = 8'h02;
    bus.clear_ovf = 1'b0;
    rst_n = 1'b0;
    repeat (5) tick();
    n_chk++; if (bus.tx !== 1'b1) $display("FAIL reset_tx got %b exp 1", bus.tx); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy); else n_pass++;
    n_chk++; if (bus.overflow !== 1'b0) $display("FAIL reset_ovf got %b exp 0", bus.overflow); else n_pass++;
    rst_n = 1'b1;
    low0 = tx_low;
    repeat (200) tick();
    n_chk++;
    if (rx_q.size() != 0 || tx_low != low0 || bus.busy !== 1'b0)
      $display("FAIL reset_idle got frames=%0d low=%0d busy=%b exp 0/0/0", rx_q.size(), tx_low - low0, bus.busy);
    else n_pass++;
  endtask

  task automatic test_single();
    int m, t;
    bit found, ok;
    rx_q.delete();
    exp_q.delete();
    drive(8'h06);
    m = cyc;
    drive(8'h02);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = rx_act;
    end
    n_chk++;
    if (!found || cur.t0 != m + 3) $display("FAIL get_latency got %0d exp 3 (found=%b)", cur.t0 - m, found);
    else n_pass++;
    if (!found) return;
    t = cur.t0;
    while (cyc < t + FRAME - 1) tick();
    n_chk++; if (bus.busy !== 1'b1 || bus.tx !== 1'b1) $display("FAIL get_stop got busy=%b tx=%b exp 1/1", bus.busy, bus.tx); else n_pass++;
    tick();
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL get_busy_end got %b exp 0", bus.busy); else n_pass++;
    drain(ok);
    n_chk++; if (rx_q.size() != 1) $display("FAIL get_count got %0d exp 1", rx_q.size()); else n_pass++;
    if (rx_q.size() > 0) begin
      n_chk++;
      if (rx_q[0].b !== 8'h06 || rx_q[0].st !== 1'b0 || rx_q[0].sp !== 1'b1)
        $display("FAIL get_frame got %h/%b/%b exp 06/0/1", rx_q[0].b, rx_q[0].st, rx_q[0].sp);
      else n_pass++;
    end
  endtask

  task automatic test_held();
    bit ok;
    rx_q.delete();
    exp_q.delete();
    repeat (50) drive(8'h22);
    drive(8'h02);
    drive(8'h22);
    drive(8'h02);
    drain(ok);
    n_chk++; if (!ok) $display("FAIL held_drain got busy=%b exp 0", bus.busy); else n_pass++;
    n_chk++; if (rx_q.size() != 2) $display("FAIL held_count got %0d exp 2", rx_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_chk++;
      if (rx_q[i].b !== exp_q[i] || rx_q[i].st !== 1'b0 || rx_q[i].sp !== 1'b1)
        $display("FAIL held_frame%0d got %h/%b/%b exp %h/0/1", i, rx_q[i].b, rx_q[i].st, rx_q[i].sp, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int m;
    bit ok;
    rx_q.delete();
    exp_q.delete();
    drive(8'h06);
    m = cyc;
    drive(8'h0A);
    drive(8'h12);
    drive(8'h42);
    drive(8'h02);
    drain(ok);
    n_chk++; if (!ok) $display("FAIL burst_drain got busy=%b exp 0", bus.busy); else n_pass++;
    n_chk++; if (rx_q.size() != exp_q.size()) $display("FAIL burst_count got %0d exp %0d", rx_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_chk++;
      if (rx_q[i].b !== exp_q[i] || rx_q[i].sp !== 1'b1 || rx_q[i].t0 != m + 3 + i * (FRAME + 1))
        $display("FAIL burst_frame%0d got %h sp=%b t=%0d exp %h sp=1 t=%0d", i, rx_q[i].b, rx_q[i].sp,
                 rx_q[i].t0 - m, exp_q[i], 3 + i * (FRAME + 1));
      else n_pass++;
    end
    n_chk++; if (bus.overflow !== 1'b0) $display("FAIL burst_ovf got %b exp 0", bus.overflow); else n_pass++;
  endtask

  task automatic test_overflow();
    int m;
    bit ok;
    rx_q.delete();
    drive(8'h06);
    m = cyc;
    drive(8'h0A);
    drive(8'h12);
    drive(8'h22);
    drive(8'h42);
    drive(8'h0E);
    tick();
    n_chk++; if (bus.overflow !== 1'b1) $display("FAIL ovf_set got %b exp 1", bus.overflow); else n_pass++;
    bus.data_in = 8'h46;
    bus.clear_ovf = 1'b1;
    last_in = 8'h46;
    tick();
    n_chk++; if (bus.overflow !== 1'b1) $display("FAIL ovf_set_wins got %b exp 1", bus.overflow); else n_pass++;
    bus.data_in = 8'h02;
    last_in = 8'h02;
    tick();
    n_chk++; if (bus.overflow !== 1'b0) $display("FAIL ovf_clear got %b exp 0", bus.overflow); else n_pass++;
    bus.clear_ovf = 1'b0;
    // first frame's pop lands on this capture edge while the FIFO is still full
    while (cyc < m + FRAME + 2) tick();
    bus.data_in = 8'h7E;
    last_in = 8'h7E;
    tick();
    n_chk++; if (bus.overflow !== 1'b0) $display("FAIL ovf_push_pop_full got %b exp 0", bus.overflow); else n_pass++;
    bus.data_in = 8'h02;
    last_in = 8'h02;
    exp_q = '{8'h06, 8'h0A, 8'h12, 8'h22, 8'h42, 8'h7E};
    drain(ok);
    n_chk++; if (!ok) $display("FAIL ovf_drain got busy=%b exp 0", bus.busy); else n_pass++;
    n_chk++; if (rx_q.size() != exp_q.size()) $display("FAIL ovf_count got %0d exp %0d", rx_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_chk++;
      if (rx_q[i].b !== exp_q[i] || rx_q[i].st !== 1'b0 || rx_q[i].sp !== 1'b1)
        $display("FAIL ovf_frame%0d got %h/%b/%b exp %h/0/1", i, rx_q[i].b, rx_q[i].st, rx_q[i].sp, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int nv;
    bit ok;
    logic [7:0] d;
    for (int r = 0; r < 3; r++) begin
      rx_q.delete();
      exp_q.delete();
      nv = 0;
      for (int i = 0; i < 12; i++) begin
        d = 8'($urandom);
        if ($urandom_range(0, 2) != 0) d[1:0] = 2'b10;
        if ($urandom_range(0, 3) == 0 || (nv == 5 && valid_code(d, last_in))) d = last_in;
        if (valid_code(d, last_in)) nv++;
        drive(d);
      end
      drive(8'h02);
      drain(ok);
      n_chk++; if (!ok) $display("FAIL rand%0d_drain got busy=%b exp 0", r, bus.busy); else n_pass++;
      n_chk++; if (rx_q.size() != exp_q.size()) $display("FAIL rand%0d_count got %0d exp %0d", r, rx_q.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
        n_chk++;
        if (rx_q[i].b !== exp_q[i] || rx_q[i].st !== 1'b0 || rx_q[i].sp !== 1'b1)
          $display("FAIL rand%0d_frame%0d got %h/%b/%b exp %h/0/1", r, i, rx_q[i].b, rx_q[i].st, rx_q[i].sp, exp_q[i]);
        else n_pass++;
      end
      n_chk++; if (bus.overflow !== 1'b0) $display("FAIL rand%0d_ovf got %b exp 0", r, bus.overflow); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_frame();
    int t, low0;
    bit found;
    rx_q.delete();
    exp_q.delete();
    drive(8'h06);
    drive(8'h0A);
    drive(8'h12);
    drive(8'h02);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = rx_act;
    end
    n_chk++; if (!found) $display("FAIL midrst_start got none exp frame"); else n_pass++;
    if (!found) return;
    t = cur.t0;
    while (cyc < t + 40) tick();
    n_chk++; if (bus.tx !== 1'b0) $display("FAIL midrst_bit3 got %b exp 0", bus.tx); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.overflow !== 1'b0)
      $display("FAIL midrst_async got tx=%b busy=%b ovf=%b exp 1/0/0", bus.tx, bus.busy, bus.overflow);
    else n_pass++;
    repeat (3) tick();
    rst_n = 1'b1;
    rx_q.delete();
    low0 = tx_low;
    repeat (400) tick();
    n_chk++;
    if (rx_q.size() != 0 || tx_low != low0 || bus.busy !== 1'b0)
      $display("FAIL midrst_residual got frames=%0d low=%0d busy=%b exp 0/0/0", rx_q.size(), tx_low - low0, bus.busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_held();
    test_back_to_back();
    test_overflow();
    test_random();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "timeout");
  end
endmodule
